// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared definitions for the game control unit.
//   STATE_W : width of the state code (also the width of the debug LED bus)
//   state_t : 3-bit state encoding
// Codes 7 is unused; the FSM steers it back to INIT.
// ---------------------------------------------------------------------------
package control_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    PLAY_FPGA  = 3'd2,
    PLAY_USER  = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Brings an asynchronous push-button level into the clock domain with a
// 2-flop synchronizer and turns its rising edge into a registered,
// single-cycle pulse.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears every flop
//   din   : asynchronous level input
//   pulse : one-cycle pulse, 3 clocks after din rises
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Two synchronizer stages, a delayed copy for edge detection, and a
  // registered pulse so the pulse itself is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_1    <= din;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      pulse     <= sync_2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Moore FSM sequencing the memory game: setup, FPGA sequence playback, user
// entry, check, next round and result display. E4 is the only Mealy output.
// Configuration macro: ENTER_SYNC_EN
//   defined   : enter goes through edge_detect (sync + rising-edge pulse)
//   undefined : enter is used directly as a synchronous one-cycle pulse
// Ports:
//   CLOCK_50  : clock, rising edge
//   reset     : asynchronous active-high reset (forces INIT)
//   enter     : user confirm, active high
//   end_FPGA, end_User, end_time, win, match : datapath status inputs
//   R1 / R2   : full game clear / round and user-timer clear
//   E1..E5    : setup load, FPGA run, user run, store entry, round increment
//   SEL       : 0 = game display, 1 = result display
//   state     : current state code for debug LEDs
// ---------------------------------------------------------------------------
module control_unit
  import control_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enter,
  input  logic               end_FPGA,
  input  logic               end_User,
  input  logic               end_time,
  input  logic               win,
  input  logic               match,
  output logic               R1,
  output logic               R2,
  output logic               E1,
  output logic               E2,
  output logic               E3,
  output logic               E4,
  output logic               E5,
  output logic               SEL,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  state_t state_d;
  logic   enter_pulse;

`ifdef ENTER_SYNC_EN
  edge_detect u_edge_detect (
    .clk   (CLOCK_50),
    .rst   (reset),
    .din   (enter),
    .pulse (enter_pulse)
  );
`else
  assign enter_pulse = enter;
`endif

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each state only looks at the inputs it consumes, so
  // stray status pulses elsewhere are ignored. end_time beats end_User.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:       state_d = SETUP;
      SETUP:      if (enter_pulse) state_d = PLAY_FPGA;
      PLAY_FPGA:  if (end_FPGA) state_d = PLAY_USER;
      PLAY_USER: begin
        if (end_time) begin
          state_d = RESULT;
        end else if (end_User) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (win) begin
          state_d = RESULT;
        end else if (match) begin
          state_d = NEXT_ROUND;
        end else begin
          state_d = RESULT;
        end
      end
      NEXT_ROUND: state_d = PLAY_FPGA;
      RESULT:     if (enter_pulse) state_d = INIT;
      default:    state_d = INIT;
    endcase
  end

  // Output decode from the registered state; E4 is additionally gated by
  // the enter pulse while the user is entering.
  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    E5  = 1'b0;
    SEL = 1'b0;
    case (state_q)
      INIT: begin
        R1 = 1'b1;
        R2 = 1'b1;
      end
      SETUP:     E1 = 1'b1;
      PLAY_FPGA: E2 = 1'b1;
      PLAY_USER: begin
        E3 = 1'b1;
        E4 = enter_pulse;
      end
      NEXT_ROUND: begin
        E5 = 1'b1;
        R2 = 1'b1;
      end
      RESULT:  SEL = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed, table-driven bench for control_unit. Input vectors are packed as
// {enter, end_FPGA, end_User, end_time, win, match}; outputs are packed as
// {R1, R2, E1, E2, E3, E4, E5, SEL}.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       enter;
  logic       end_FPGA;
  logic       end_User;
  logic       end_time;
  logic       win;
  logic       match;
  logic       R1, R2, E1, E2, E3, E4, E5, SEL;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] in_vec;
    logic [7:0] exp_out;
    logic [2:0] exp_next;
  } vec_t;

  control_unit dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enter    (enter),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .E5       (E5),
    .SEL      (SEL),
    .state    (state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Drive all six inputs at once
  task automatic applyStimulus(input logic [5:0] v);
    {enter, end_FPGA, end_User, end_time, win, match} = v;
  endtask

  // One comparison; every failure prints a single FAIL line
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {R1, R2, E1, E2, E3, E4, E5, SEL};
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Pulse reset away from the clock edge, then clock into SETUP
  task automatic doReset();
    applyStimulus(6'b000000);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_ENTER = 6'b100000;
  localparam logic [5:0] I_EFPGA = 6'b010000;
  localparam logic [5:0] I_EUSER = 6'b001000;
  localparam logic [5:0] I_ETIME = 6'b000100;
  localparam logic [5:0] I_WIN   = 6'b000010;
  localparam logic [5:0] I_MATCH = 6'b000001;

  localparam logic [7:0] O_INIT  = 8'b11000000;
  localparam logic [7:0] O_SETUP = 8'b00100000;
  localparam logic [7:0] O_PFPGA = 8'b00010000;
  localparam logic [7:0] O_PUSER = 8'b00001000;
  localparam logic [7:0] O_PUSE4 = 8'b00001100;
  localparam logic [7:0] O_CHECK = 8'b00000000;
  localparam logic [7:0] O_NEXT  = 8'b01000010;
  localparam logic [7:0] O_RES   = 8'b00000001;

  initial begin
    vec_t vecs[23];
    int   e4_count;
    int   e5_count;

    reset = 1'b1;
    applyStimulus(I_NONE);
    #12;
    checkOutput("reset_outputs", outs(), O_INIT);
    checkOutput("reset_state", {5'd0, state}, 8'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;

`ifndef ENTER_SYNC_EN
    // Walk the FSM: outputs seen with the inputs applied, then next state
    vecs[0]  = '{I_NONE,                       O_INIT,  3'd1};
    vecs[1]  = '{I_EFPGA,                      O_SETUP, 3'd1};
    vecs[2]  = '{I_ENTER,                      O_SETUP, 3'd2};
    vecs[3]  = '{I_EUSER,                      O_PFPGA, 3'd2};
    vecs[4]  = '{I_ENTER,                      O_PFPGA, 3'd2};
    vecs[5]  = '{I_EFPGA,                      O_PFPGA, 3'd3};
    vecs[6]  = '{I_ENTER,                      O_PUSE4, 3'd3};
    vecs[7]  = '{I_NONE,                       O_PUSER, 3'd3};
    vecs[8]  = '{I_EUSER | I_MATCH,            O_PUSER, 3'd4};
    vecs[9]  = '{I_MATCH,                      O_CHECK, 3'd5};
    vecs[10] = '{I_NONE,                       O_NEXT,  3'd2};
    vecs[11] = '{I_EFPGA,                      O_PFPGA, 3'd3};
    vecs[12] = '{I_EUSER | I_ETIME,            O_PUSER, 3'd6};
    vecs[13] = '{I_EUSER,                      O_RES,   3'd6};
    vecs[14] = '{I_ENTER,                      O_RES,   3'd0};
    vecs[15] = '{I_NONE,                       O_INIT,  3'd1};
    vecs[16] = '{I_ENTER,                      O_SETUP, 3'd2};
    vecs[17] = '{I_EFPGA,                      O_PFPGA, 3'd3};
    vecs[18] = '{I_EUSER,                      O_PUSER, 3'd4};
    vecs[19] = '{I_NONE,                       O_CHECK, 3'd6};
    vecs[20] = '{I_ENTER,                      O_RES,   3'd0};
    vecs[21] = '{I_ENTER,                      O_INIT,  3'd1};
    vecs[22] = '{I_WIN | I_MATCH | I_ETIME,    O_SETUP, 3'd1};

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].in_vec);
      #1;
      checkOutput($sformatf("vec%0d_out", i), outs(), vecs[i].exp_out);
      tick();
      checkOutput($sformatf("vec%0d_next", i), {5'd0, state}, {5'd0, vecs[i].exp_next});
    end

    // Reset in the middle of PLAY_USER takes effect without a clock
    doReset();
    applyStimulus(I_ENTER);
    tick();
    applyStimulus(I_EFPGA);
    tick();
    applyStimulus(I_NONE);
    checkOutput("s1_in_play_user", {5'd0, state}, 8'd3);
    reset = 1'b1;
    #1;
    checkOutput("s1_async_outs", outs(), O_INIT);
    checkOutput("s1_async_state", {5'd0, state}, 8'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    tick();
    checkOutput("s1_after_release", {5'd0, state}, 8'd1);

    // Full win path
    doReset();
    applyStimulus(I_ENTER);
    tick();
    applyStimulus(I_NONE);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("s2_fpga_hold", {5'd0, state}, 8'd2);
    applyStimulus(I_EFPGA);
    tick();
    e4_count = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? I_ENTER : I_NONE);
      #1;
      if (E4) e4_count++;
      tick();
    end
    checkOutput("s2_e4_count", 8'(e4_count), 8'd3);
    checkOutput("s2_still_user", {5'd0, state}, 8'd3);
    applyStimulus(I_EUSER | I_WIN | I_MATCH);
    tick();
    checkOutput("s2_check_state", {5'd0, state}, 8'd4);
    checkOutput("s2_check_outs", outs(), O_CHECK);
    tick();
    checkOutput("s2_result_state", {5'd0, state}, 8'd6);
    checkOutput("s2_result_sel", {7'd0, SEL}, 8'd1);

    // Three matched rounds
    doReset();
    applyStimulus(I_ENTER);
    tick();
    e5_count = 0;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(I_EFPGA);
      tick();
      applyStimulus(I_EUSER | I_MATCH);
      tick();
      applyStimulus(I_MATCH);
      tick();
      checkOutput($sformatf("s3_next_outs_r%0d", r), outs(), O_NEXT);
      if (E5) e5_count++;
      applyStimulus(I_NONE);
      tick();
      checkOutput($sformatf("s3_back_fpga_r%0d", r), outs(), O_PFPGA);
    end
    checkOutput("s3_e5_count", 8'(e5_count), 8'd3);
`else
    // Held enter yields one transition, three clocks after the rise
    tick();
    checkOutput("s5_setup", {5'd0, state}, 8'd1);
    applyStimulus(I_ENTER);
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkOutput($sformatf("s5_cycle%0d", i), {5'd0, state}, (i < 4) ? 8'd1 : 8'd2);
    end
    checkOutput("s5_fpga_outs", outs(), O_PFPGA);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have exactly one clock, CLOCK_50, an input of width 1, active on its rising edge.
REQ-002 The block SHALL have a reset input, reset, of width 1; reset SHALL be asynchronous and active-high.
REQ-003 The block SHALL have an input enter, width 1, which is the active-high user confirm (KEY inverted at top).
REQ-004 The block SHALL have status inputs end_FPGA, end_User, end_time, win and match, each width 1, driven by the Datapath.
REQ-005 The block SHALL have outputs R1 and R2, each width 1: R1 is the full game clear and R2 is the round/user-timer clear.
REQ-006 The block SHALL have enable outputs E1 to E5, each width 1:
- E1 = setup load
- E2 = FPGA sequence run
- E3 = user timer/counter run
- E4 = store user entry
- E5 = round increment
REQ-007 The block SHALL have an output SEL, width 1, where 0 selects the game display and 1 selects the result display.
REQ-008 The block SHALL have an output state, width 3, which is the current state code for debug LEDs.

Function
REQ-009 The block SHALL implement a Moore FSM with the states INIT, SETUP, PLAY_FPGA, PLAY_USER, CHECK, NEXT_ROUND and RESULT; the sole Mealy output SHALL be E4.
REQ-010 INIT SHALL drive R1=1 and R2=1 and SHALL go to SETUP unconditionally on the next cycle.
REQ-011 SETUP SHALL drive E1=1 and SHALL go to PLAY_FPGA on enter_pulse; otherwise it SHALL hold.
REQ-012 PLAY_FPGA SHALL drive E2=1 and SHALL go to PLAY_USER when end_FPGA=1; otherwise it SHALL hold.
REQ-013 PLAY_USER SHALL drive E3=1 and E4=enter_pulse.
- If end_time=1, it SHALL go to RESULT.
- Else if end_User=1, it SHALL go to CHECK.
- Otherwise it SHALL hold.
- end_time SHALL have priority when end_time and end_User are asserted in the same cycle.
REQ-014 CHECK SHALL last exactly 1 cycle with all outputs idle.
- If win=1, it SHALL go to RESULT.
- Else if match=1, it SHALL go to NEXT_ROUND.
- Else it SHALL go to RESULT.
REQ-015 NEXT_ROUND SHALL last exactly 1 cycle with E5=1 and R2=1, then SHALL go to PLAY_FPGA.
REQ-016 RESULT SHALL drive SEL=1 and SHALL go to INIT on enter_pulse; otherwise it SHALL hold.
REQ-017 Every output not listed for a state SHALL be 0 in that state.
REQ-018 The block SHALL assert at most one of E1, E2, E3 and E5 in any cycle.
REQ-019 Status inputs SHALL be sampled only in the states that consume them; assertions of a status input in any other state SHALL be ignored.
REQ-020 An enter_pulse SHALL be consumed by at most one transition or E4 strobe, so a single press SHALL never skip a state.
REQ-021 Output latency SHALL be exactly 1 cycle: all outputs SHALL be decoded from the registered state, and E4 SHALL additionally be gated by enter_pulse.
REQ-022 Unused state codes SHALL transition to INIT on the next cycle.

Reset
REQ-023 While reset=1, the state register SHALL be INIT immediately, independent of CLOCK_50, so that R1=1, R2=1, E1 to E5=0, SEL=0 and state=INIT code.
REQ-024 Reset asserted in any state, including mid-round, SHALL abandon the round.
REQ-025 After reset deassertion, the first clock SHALL move the FSM to SETUP.
REQ-026 The synchronizer and edge-detect flops SHALL reset to 0, so that enter held through reset produces no pulse on release.

Configuration
REQ-027 With ENTER_SYNC_EN defined, enter SHALL pass through a 2-flop synchronizer and then a rising-edge detector.
- enter_pulse SHALL be 1 cycle wide.
- Latency from the enter rise to enter_pulse SHALL be 3 clocks.
- Holding enter SHALL give exactly one pulse.
REQ-028 Without ENTER_SYNC_EN, enter_pulse SHALL equal enter directly.
- The upstream source is then required to supply a synchronous 1-cycle pulse.
- A held level SHALL be treated as one pulse per cycle.

Structure
REQ-029 A shared package control_pkg SHALL hold the 3-bit state encoding (INIT=0, SETUP=1, PLAY_FPGA=2, PLAY_USER=3, CHECK=4, NEXT_ROUND=5, RESULT=6) and the state width constant.
REQ-030 The synchronizer and edge detector SHALL be one sub-module, edge_detect, instantiated only under ENTER_SYNC_EN.

Verification
REQ-031 Scenario 1: assert reset mid-PLAY_USER -> the same-cycle outputs SHALL be R1=1, R2=1, E*=0, state=0; the first clock after release SHALL give state=1.
REQ-032 Scenario 2: full win path (enter in SETUP, end_FPGA after 5 cycles, 3 enter pulses in PLAY_USER, then end_User=1 with match=1 and win=1) -> the bench SHALL check:
- E4 pulses 3 times
- the CHECK state lasts 1 cycle
- the result is RESULT with SEL=1
REQ-033 Scenario 3: match=1, win=0 in CHECK -> NEXT_ROUND SHALL last 1 cycle with E5=1 and R2=1, then PLAY_FPGA with E2=1; repeating this 3 times SHALL give 3 E5 pulses.
REQ-034 Scenario 4: end_time=1 and end_User=1 in the same PLAY_USER cycle -> the next state SHALL be RESULT, not CHECK; match=0 in CHECK -> RESULT.
REQ-035 Scenario 5: with ENTER_SYNC_EN, enter held high for 20 cycles in SETUP -> exactly one transition SHALL occur, 3 cycles after the enter rise, and PLAY_FPGA SHALL not advance without end_FPGA.
REQ-036 Scenario 6: status inputs pulsed in the wrong states (end_FPGA in SETUP, end_User in PLAY_FPGA) -> no transition SHALL occur; the enter press in RESULT SHALL return the FSM to INIT with R1=1.
